// File: rtl/fb_id_ex.sv
// fb_id_ex: ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded control and datapath operands of the ID stage every
// cycle. It inserts a bubble on flush or on a load-use hazard and freezes on a
// downstream hold. Priority on each edge is flush > hold > load-use > normal.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_*              ID-stage valid, control, operands, register indices, funct
//   flush_i           kill the ID instruction (EX-resolved redirect)
//   hold_i            freeze ID/EX (downstream memory stall)
//   stall_o           load-use stall request to PC and IF/ID
//   ex_*              registered ID/EX contents
//   perf_bubble_cnt   load-use bubbles inserted (saturating)
//   perf_flush_cnt    valid instructions killed by flush (saturating)
//
// Configuration: define FB_PERF_CNT_EN to build the performance counters.
// Without it, both counter ports are tied to zero.
module fb_id_ex #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [1:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_alu_res_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic            id_mem_to_reg,
    input  logic            id_reg_write,
    input  logic            id_pc_src,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_funct,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_alu_res_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_mem_to_reg,
    output logic            ex_reg_write,
    output logic            ex_pc_src,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_flush_cnt
);

    localparam int unsigned CtrlW = 10;

    logic [CtrlW-1:0] id_ctrl, ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [3:0]       funct_q;
    logic             load_use;

    assign id_ctrl = {id_alu_op, id_alu_src, id_alu_res_src, id_mem_read, id_mem_write,
                      id_branch, id_mem_to_reg, id_reg_write, id_pc_src};

    assign {ex_alu_op, ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write,
            ex_branch, ex_mem_to_reg, ex_reg_write, ex_pc_src} = ctrl_q;

    // x0 never carries a hazard, hence the rd != 0 term.
    assign load_use = valid_q & ex_mem_read & (rd_q != 5'd0) & id_valid &
                      ((rd_q == id_rs1) | (rd_q == id_rs2));

    assign stall_o = load_use & ~flush_i & ~hold_i;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (hold_i) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
        end else if (load_use) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Data fields are don't-care inside a bubble, so they only honour hold_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= '0;
        end else if (!hold_i) begin
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            funct_q    <= id_funct;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct    = funct_q;

`ifdef FB_PERF_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stall_o && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        // Count only flushes that actually kill a valid ID instruction.
        if (flush_i && id_valid && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`else
    assign perf_bubble_cnt = 32'h0;
    assign perf_flush_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_fb_id_ex.sv
module tb_fb_id_ex;

`ifdef FB_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_alu_res_src, id_mem_read, id_mem_write;
    logic        id_branch, id_mem_to_reg, id_reg_write, id_pc_src;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        flush_i, hold_i, stall_o, ex_valid;
    logic [1:0]  ex_alu_op;
    logic        ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_mem_to_reg, ex_reg_write, ex_pc_src;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    fb_id_ex #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_alu_res_src(id_alu_res_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_pc_src(id_pc_src),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct(id_funct), .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_alu_res_src(ex_alu_res_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_pc_src(ex_pc_src), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic        mrd;
        logic        rw;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        flush;
        logic        hold;
        logic        e_stall;   // before the edge
        logic        e_valid;   // after the edge
        logic        e_mrd;
        logic        e_rw;
        logic [4:0]  e_rd;      // checked only when e_valid
        logic [31:0] e_pc;      // checked only when e_valid
        logic [31:0] e_bub;     // counter values with counters built
        logic [31:0] e_fl;
    } vec_t;

    vec_t vecs[15];

    task automatic drive(input vec_t v);
        id_valid     = v.vld;
        id_mem_read  = v.mrd;
        id_reg_write = v.rw;
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        id_rd        = v.rd;
        id_pc        = v.pc;
        flush_i      = v.flush;
        hold_i       = v.hold;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, " ex_ctrl"}, {22'd0, ex_alu_op, ex_alu_src, ex_alu_res_src, ex_mem_read,
            ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write, ex_pc_src}, 32'd0);
        chk({tag, " ex_pc"}, ex_pc, 32'd0);
        chk({tag, " ex_rd"}, {27'd0, ex_rd}, 32'd0);
        chk({tag, " stall_o"}, {31'd0, stall_o}, 32'd0);
        chk({tag, " bubble_cnt"}, perf_bubble_cnt, 32'd0);
        chk({tag, " flush_cnt"}, perf_flush_cnt, 32'd0);
    endtask

    initial begin
        //          vld mrd rw rs1 rs2 rd  pc       fl ho | stl val mrd rw rd pc      bub fl
        vecs[0]  = '{1, 1, 1, 1, 0, 5, 32'h10, 0, 0, 0, 1, 1, 1, 5, 32'h10, 0, 0}; // lw x5
        vecs[1]  = '{1, 0, 1, 3, 5, 7, 32'h14, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};      // add: use
        vecs[2]  = '{1, 0, 1, 3, 5, 7, 32'h14, 0, 0, 0, 1, 0, 1, 7, 32'h14, 1, 0}; // replay
        vecs[3]  = '{1, 1, 1, 2, 0, 0, 32'h18, 0, 0, 0, 1, 1, 1, 0, 32'h18, 1, 0}; // lw x0
        vecs[4]  = '{1, 0, 1, 0, 0, 8, 32'h1c, 0, 0, 0, 1, 0, 1, 8, 32'h1c, 1, 0}; // x0 no haz
        vecs[5]  = '{0, 1, 1, 0, 0, 9, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};      // invalid
        vecs[6]  = '{1, 1, 1, 1, 0, 6, 32'h24, 0, 0, 0, 1, 1, 1, 6, 32'h24, 1, 0}; // lw x6
        vecs[7]  = '{1, 0, 1, 6, 2, 7, 32'h28, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};      // use+flush
        vecs[8]  = '{1, 1, 1, 1, 0, 6, 32'h40, 0, 0, 0, 1, 1, 1, 6, 32'h40, 1, 1}; // lw pc 40
        vecs[9]  = '{1, 0, 1, 6, 2, 9, 32'h44, 0, 1, 0, 1, 1, 1, 6, 32'h40, 1, 1}; // hold 1
        vecs[10] = '{1, 0, 1, 6, 2, 9, 32'h44, 0, 1, 0, 1, 1, 1, 6, 32'h40, 1, 1}; // hold 2
        vecs[11] = '{1, 0, 1, 6, 2, 9, 32'h44, 0, 1, 0, 1, 1, 1, 6, 32'h40, 1, 1}; // hold 3
        vecs[12] = '{1, 0, 1, 1, 2, 9, 32'h44, 0, 0, 0, 1, 0, 1, 9, 32'h44, 1, 1}; // release
        vecs[13] = '{1, 1, 1, 1, 2, 3, 32'h48, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2};      // fl+hold
        vecs[14] = '{0, 1, 1, 1, 2, 3, 32'h4c, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2};      // fl, no vld

        id_alu_op = 2'b10; id_alu_src = 1'b1; id_alu_res_src = 1'b0; id_mem_write = 1'b0;
        id_branch = 1'b0; id_mem_to_reg = 1'b1; id_pc_src = 1'b0;
        id_rs1_data = 32'h1111; id_rs2_data = 32'h2222; id_imm = 32'h4; id_funct = 4'h0;
        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 chk($sformatf("v%0d stall_o", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d ex_mem_read", i), {31'd0, ex_mem_read}, {31'd0, vecs[i].e_mrd});
            chk($sformatf("v%0d ex_reg_write", i), {31'd0, ex_reg_write},
                {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d ex_alu_op", i), {30'd0, ex_alu_op},
                vecs[i].e_valid ? 32'd2 : 32'd0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
                chk($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].e_pc);
            end
            chk($sformatf("v%0d bubble_cnt", i), perf_bubble_cnt,
                PerfEn ? vecs[i].e_bub : 32'd0);
            chk($sformatf("v%0d flush_cnt", i), perf_flush_cnt,
                PerfEn ? vecs[i].e_fl : 32'd0);
        end

        // Hold keeps stall_o low even while the load-use condition is present.
        @(negedge clk);
        drive('{1, 1, 1, 1, 0, 5, 32'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        drive('{1, 0, 1, 5, 0, 7, 32'h54, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        #1 chk("hold masks stall", {31'd0, stall_o}, 32'd0);
        hold_i = 1'b0;
        #1 chk("stall after hold", {31'd0, stall_o}, 32'd1);

        // Asynchronous reset mid-cycle while stalled and ex_valid=1.
        chk("pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check_zero("async reset");
        @(negedge clk) rst_n = 1'b1;
        // The stalled add is discarded; upstream restarts it.
        @(posedge clk) #1;
        chk("restart ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("restart ex_rd", {27'd0, ex_rd}, 32'd7);
        chk("restart ex_pc", ex_pc, 32'h54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
